// File: rtl/regbank_arb_pkg.sv
// Shared types and constants for the round-robin register-bank write arbiter.
// The struct below describes the write stage for the default configuration.
package regbank_arb_pkg;

  // Width of a requester index. A single requester still gets one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);
  localparam int DEF_ID_W  = id_w(DEF_NREQ);

  typedef struct packed {
    logic                 valid;
    logic [DEF_AW-1:0]    addr;
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_ID_W-1:0]  id;
  } wr_stage_t;

  localparam logic [DEF_WIDTH-1:0] RD_DATA_RST = '0;

endpackage

// File: rtl/regbank_wr_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: the first asserted request at or
// above ptr (wrapping) wins. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any_grant
);

  always_comb begin : pick
    int j;
    j         = 0;
    any_grant = 1'b0;
    gnt_idx   = '0;
    gnt       = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        gnt_idx   = IDW'(j);
      end
    end
    if (!en) begin
      any_grant = 1'b0;
      gnt_idx   = '0;
    end
    if (any_grant) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbitration of NREQ writers onto one register bank, one commit
// per cycle through a single write stage, plus a registered read port.
module regbank_wr_arbiter
  import regbank_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int ID_W  = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  stall,
  output logic                  wr_done,
  output logic [ID_W-1:0]       wr_done_id,
  output logic                  wr_err,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid
);

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [ID_W-1:0]  id;
  } stage_t;

  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             any_gnt;
  logic [ID_W-1:0]  rr_ptr_d, rr_ptr_q;
  stage_t           stage_d, stage_q;
  logic             rd_valid_d, rd_valid_q;
  logic [WIDTH-1:0] rd_data_d, rd_data_q;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             in_range;
  logic             commit;

  rr_arbiter #(.N(NREQ), .IDW(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .en        (!stall && !rst),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_grant (any_gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    stage_d  = '0;
    if (any_gnt) begin
      rr_ptr_d      = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      stage_d.valid = 1'b1;
      stage_d.addr  = req_addr[int'(gnt_idx)*AW +: AW];
      stage_d.data  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
      stage_d.id    = gnt_idx;
    end
  end

  // A reset cycle swallows the staged write: no done pulse, no bank update.
  assign in_range = int'(stage_q.addr) < DEPTH;
  assign commit   = stage_q.valid && !rst;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++)
      wr_en[i] = commit && in_range && (int'(stage_q.addr) == i);
  end

  assign wr_done    = commit;
  assign wr_err     = commit && !in_range;
  assign wr_done_id = commit ? stage_q.id : '0;

  // The staged write is forwarded so a read racing its commit sees new data.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      if (int'(rd_addr) >= DEPTH)
        rd_data_d = '0;
      else if (stage_q.valid && stage_q.addr == rd_addr)
        rd_data_d = stage_q.data;
      else
        rd_data_d = bank_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      stage_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= WIDTH'(RD_DATA_RST);
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      stage_q    <= stage_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst)          bank_q[i] <= '0;
      else if (wr_en[i]) bank_q[i] <= stage_q.data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
Shares one bank of DEPTH enable-gated WIDTH-bit registers between NREQ independent writers using round-robin arbitration, with one write committed per cycle. Provides a registered read port with write-forwarding. It sits between multiple producers (CSR masters, config engines) and a shared configuration/state register bank.

Parameters:
NREQ, 4, number of write requesters (>=2)
WIDTH, 32, register data width
DEPTH, 16, number of registers in the bank (>=2; need not be a power of 2)
AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester write request
req_addr  input  NREQ*AW  packed write addresses; requester i at [i*AW +: AW]
req_data  input  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot-or-zero grant
stall  input  1  blocks new grants while high
wr_done  output  1  one-cycle pulse when a write commits
wr_done_id  output  $clog2(NREQ)  requester index of the committed write
wr_err  output  1  qualifies wr_done: address >= DEPTH, write dropped
rd_en  input  1  read request
rd_addr  input  AW  read address
rd_data  output  WIDTH  read data
rd_valid  output  1  rd_data valid

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst is sampled only on the rising edge of clk.
- Reset values: all bank entries 0, rr_ptr 0, write stage empty, wr_done/wr_err/wr_done_id 0, rd_valid 0, rd_data 0.
- Grant (combinational):
  - Find the first i with req_valid[i], scanning upward from rr_ptr with wrap at NREQ.
  - req_ready[i]=1 only for that i, and only when stall=0 and rst=0.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Pointer: on a transfer from i, rr_ptr <= (i+1) mod NREQ. With no transfer, rr_ptr holds.
- Write stage: a transfer at cycle t loads {addr, data, id} into the stage, which is valid at t+1.
- Commit at t+1:
  - If addr < DEPTH, bank[addr] is written at the end of t+1.
  - wr_done=1 and wr_done_id=id during t+1.
  - wr_err=1 if addr >= DEPTH; the bank is then unchanged.
- Throughput: one accepted write per cycle, back-to-back.
- stall affects only new grants. A write already in the stage still commits.
- Read:
  - rd_en at cycle t gives rd_valid=1 and rd_data at t+1.
  - If the write stage is valid at t with a matching in-range address, rd_data is the stage data (forwarded).
  - Otherwise rd_data is bank[rd_addr].
  - rd_addr >= DEPTH returns 0.
  - A write accepted in the same cycle t as the read is not visible to that read.
  - rd_en=0 gives rd_valid=0 at t+1; rd_data holds its last value.
- Simultaneous read and commit to the same address return the new data via forwarding.
- Reset mid-operation: rst=1 discards the write stage (no wr_done, no bank write), clears the bank and forces req_ready=0 in that cycle.
- req_valid may drop without a grant. The requester must hold addr/data stable while valid and not ready (checked by assertion in the bench, not in RTL).

Decomposition:
- Package regbank_arb_pkg:
  - localparam ID_W function (clog2 with a minimum of 1)
  - typedef struct wr_stage_t {valid, addr, data, id}, parameterised via package localparams set to defaults
  - reset constant for rd_data
- Sub-module rr_arbiter: combinational rotating-priority pick from req, ptr and en. Outputs a one-hot grant, its index and any_grant. The rr_ptr register stays in the top block.
- Bank: a plain always_ff array with a per-entry write enable.

Test Plan:
1. Reset, then rd_en at addr 3 -> rd_valid=1, rd_data=0 next cycle. rr_ptr=0 verified by req0 and req1 both valid -> req_ready=4'b0001.
2. All four req_valid held high for 5 cycles, distinct addresses -> grants 0,1,2,3,0. wr_done_id sequence lags by one cycle. Bank holds all four values.
3. req1 writes addr 5, data 0xDEADBEEF, accepted at t -> wr_done=1, id=1 at t+1. rd_en addr 5 at t+1 -> 0xDEADBEEF at t+2 (forwarded). rd_en addr 5 at t+2 -> 0xDEADBEEF from the bank.
4. rr_ptr=2, req0 and req2 valid, stall=1 for 3 cycles -> req_ready=0, no wr_done. Stall released -> req2 granted first, then req0.
5. DEPTH=12, req3 writes addr 13 -> wr_done=1, wr_err=1, id=3. All bank entries unchanged. Read at addr 13 -> 0.
6. Write accepted at t, rst=1 at t+1 -> no wr_done at t+1. Read of that address after reset -> 0. req_ready=0 during rst.
